// File: rtl/clk_en_seq.sv
// PLL lock supervisor with staggered per-channel reset release and
// programmable divide/phase clock-enable strobes derived from one fast clock.
module clk_en_seq #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int RELEASE_GAP = 4,
  parameter int DIV_RST     = 1,
  parameter int PHASE_RST   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    cfg_load,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH*DIV_W-1:0] phase_in,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic                    ready
);

  localparam int NW      = NUM_CH * DIV_W;
  localparam int DBC_W   = $clog2(LOCK_CYCLES + 1);
  localparam int REL_END = NUM_CH * RELEASE_GAP;
  localparam int REL_W   = $clog2(REL_END + 1);

  localparam logic [NW-1:0] DIV_SH_RST   = {NUM_CH{DIV_W'(DIV_RST)}};
  localparam logic [NW-1:0] PHASE_SH_RST = {NUM_CH{DIV_W'(PHASE_RST)}};

  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN} state_t;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] d,
                                                 input logic [DIV_W-1:0] p);
    logic [DIV_W-1:0] de;
    de = eff_div(d);
    return (p >= de) ? de - DIV_W'(1) : p;
  endfunction

  state_t           state;
  logic             lk_p0;
  logic             lk_p1;
  logic [DBC_W-1:0] dbc;
  logic [REL_W-1:0] rel_cnt;
  logic [NW-1:0]    div_sh;
  logic [NW-1:0]    phase_sh;
  logic [DIV_W-1:0] cnt     [NUM_CH];
  logic [DIV_W-1:0] cnt_ent [NUM_CH];
  logic [DIV_W-1:0] cnt_run [NUM_CH];
  logic [NW-1:0]    div_nx;
  logic [NW-1:0]    phase_nx;

  // A load on the same edge as a reload or RUN entry uses the incoming values
  assign div_nx   = cfg_load ? div_in   : div_sh;
  assign phase_nx = cfg_load ? phase_in : phase_sh;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_ent[i] = eff_phase(div_nx[i*DIV_W +: DIV_W], phase_nx[i*DIV_W +: DIV_W]);
      cnt_run[i] = (cnt[i] == '0) ? eff_div(div_nx[i*DIV_W +: DIV_W]) - DIV_W'(1)
                                  : cnt[i] - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      lk_p0     <= 1'b0;
      lk_p1     <= 1'b0;
      dbc       <= '0;
      rel_cnt   <= '0;
      div_sh    <= DIV_SH_RST;
      phase_sh  <= PHASE_SH_RST;
      ce        <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      // stage p0 -> p1: lock synchroniser
      lk_p0 <= pll_locked;
      lk_p1 <= lk_p0;

      if (cfg_load) begin
        div_sh   <= div_in;
        phase_sh <= phase_in;
      end

      case (state)
        WAIT_LOCK: begin
          ce        <= '0;
          rst_out_n <= '0;
          ready     <= 1'b0;
          rel_cnt   <= '0;
          if (!lk_p1) begin
            dbc <= '0;
          end else if (dbc == DBC_W'(LOCK_CYCLES - 1)) begin
            state        <= RELEASE;
            dbc          <= '0;
            rst_out_n[0] <= 1'b1;
          end else if (dbc != DBC_W'(LOCK_CYCLES)) begin
            dbc <= dbc + 1'b1;
          end
        end

        RELEASE: begin
          if (!lk_p1) begin
            state     <= WAIT_LOCK;
            ce        <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
            dbc       <= '0;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
            for (int i = 0; i < NUM_CH; i++)
              rst_out_n[i] <= (int'(rel_cnt) + 1 >= i * RELEASE_GAP);
            if (int'(rel_cnt) + 1 == REL_END) begin
              state <= RUN;
              ready <= 1'b1;
              for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_ent[i];
                ce[i]  <= (cnt_ent[i] == '0);
              end
            end
          end
        end

        RUN: begin
          if (!lk_p1) begin
            state     <= WAIT_LOCK;
            ce        <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
            dbc       <= '0;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              cnt[i] <= cnt_run[i];
              ce[i]  <= (cnt_run[i] == '0);
            end
          end
        end

        default: begin
          state     <= WAIT_LOCK;
          ce        <= '0;
          rst_out_n <= '0;
          ready     <= 1'b0;
          dbc       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_seq.sv
// Bench for clk_en_seq: directed scenarios plus random lock/config traffic,
// checked every cycle against an event-schedule model of the sequencer.
module tb_clk_en_seq;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int RELEASE_GAP = 4;
  localparam int DIV_RST     = 1;
  localparam int PHASE_RST   = 0;
  localparam int NW          = NUM_CH * DIV_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_locked;
  logic              cfg_load;
  logic [NW-1:0]     div_in;
  logic [NW-1:0]     phase_in;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] rst_out_n;
  logic              ready;

  clk_en_seq #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
    .RELEASE_GAP(RELEASE_GAP), .DIV_RST(DIV_RST), .PHASE_RST(PHASE_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .cfg_load(cfg_load),
    .div_in(div_in), .phase_in(phase_in), .ce(ce), .rst_out_n(rst_out_n),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  // Reference model: mode 0 = waiting for lock, 1 = releasing, 2 = running.
  int   m_mode;
  int   m_t;
  int   m_run;
  logic m_s1;
  logic m_lk;
  int   sh_div [NUM_CH];
  int   sh_ph  [NUM_CH];
  int   m_nxt  [NUM_CH];

  logic [NW-1:0] cur_d;
  logic [NW-1:0] cur_p;

  function automatic int eff_d(int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int eff_p(int d, int p);
    int de;
    de = eff_d(d);
    return (p >= de) ? de - 1 : p;
  endfunction

  function automatic logic [NW-1:0] pack3(int a, int b, int c);
    logic [NW-1:0] v;
    v = '0;
    v[0*DIV_W +: DIV_W] = DIV_W'(a);
    v[1*DIV_W +: DIV_W] = DIV_W'(b);
    v[2*DIV_W +: DIV_W] = DIV_W'(c);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_run = 0; m_s1 = 1'b0; m_lk = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sh_div[i] = DIV_RST; sh_ph[i] = PHASE_RST; m_nxt[i] = 0;
    end
  endtask

  task automatic model_edge(input logic pl, input logic ld,
                            input logic [NW-1:0] d, input logic [NW-1:0] p);
    logic lk_now;
    lk_now = m_lk;
    m_lk   = m_s1;
    m_s1   = pl;
    if (ld) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_div[i] = int'(d[i*DIV_W +: DIV_W]);
        sh_ph[i]  = int'(p[i*DIV_W +: DIV_W]);
      end
    end
    if (m_mode == 0) begin
      if (lk_now) begin
        m_run++;
        if (m_run == LOCK_CYCLES) begin m_mode = 1; m_t = 0; end
      end else begin
        m_run = 0;
      end
    end else if (!lk_now) begin
      m_mode = 0; m_run = 0;
    end else if (m_mode == 1) begin
      m_t++;
      if (m_t == NUM_CH * RELEASE_GAP) begin
        m_mode = 2; m_t = 0;
        for (int i = 0; i < NUM_CH; i++) m_nxt[i] = eff_p(sh_div[i], sh_ph[i]);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (m_t == m_nxt[i]) m_nxt[i] = m_t + eff_d(sh_div[i]);
      m_t++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic pl, input logic ld, input string tag);
    logic [NUM_CH-1:0] ec, er;
    logic              ed;
    pll_locked = pl; cfg_load = ld; div_in = cur_d; phase_in = cur_p;
    @(posedge clk);
    model_edge(pl, ld, cur_d, cur_p);
    stepn++;
    #1;
    ec = '0; er = '0; ed = 1'b0;
    if (m_mode == 1) begin
      for (int i = 0; i < NUM_CH; i++) er[i] = (m_t >= i * RELEASE_GAP);
    end else if (m_mode == 2) begin
      for (int i = 0; i < NUM_CH; i++) ec[i] = (m_t == m_nxt[i]);
      er = '1; ed = 1'b1;
    end
    chk(tag, 32'({ce, rst_out_n, ready}), 32'({ec, er, ed}));
  endtask

  int          first_rst0;
  int          first_rdy;
  logic [2:0]  runv [9];
  logic [2:0]  exp_runv [9];
  logic        ce0v [9];
  logic        exp_ce0 [9];

  initial begin
    exp_runv = '{3'b101, 3'b100, 3'b110, 3'b100, 3'b101, 3'b110, 3'b100, 3'b100, 3'b111};
    exp_ce0  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0;
    cur_d = '0; cur_p = '0; div_in = '0; phase_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;

    // Boot with default shadow values
    stepn = 0; first_rst0 = -1; first_rdy = -1;
    repeat (40) begin
      step(1'b1, 1'b0, "boot");
      if (first_rst0 < 0 && rst_out_n[0]) first_rst0 = stepn;
      if (first_rdy < 0 && ready) first_rdy = stepn;
    end
    chk("boot_rst0_step", 32'(first_rst0), 32'd18);
    chk("boot_ready_step", 32'(first_rdy), 32'd30);
    chk("boot_ce_all", 32'(ce), 32'b111);

    // Lock loss from RUN, config load while waiting, then a one-cycle glitch
    cur_d = pack3(4, 3, 0); cur_p = pack3(0, 2, 7);
    step(1'b0, 1'b0, "drop");
    step(1'b0, 1'b1, "drop_cfg");
    step(1'b0, 1'b0, "drop");
    chk("drop_ready", 32'(ready), 32'd0);
    chk("drop_rst_out_n", 32'(rst_out_n), 32'd0);
    repeat (10) step(1'b1, 1'b0, "glitch_hi");
    step(1'b0, 1'b0, "glitch_lo");
    stepn = 0; first_rst0 = -1;
    repeat (45) begin
      step(1'b1, 1'b0, "relock");
      if (first_rst0 < 0 && rst_out_n[0]) first_rst0 = stepn;
      if (stepn >= 30 && stepn <= 38) runv[stepn-30] = ce;
    end
    chk("glitch_rst0_step", 32'(first_rst0), 32'd18);
    for (int k = 0; k < 9; k++) chk($sformatf("phase_ce_cyc%0d", k), 32'(runv[k]), 32'(exp_runv[k]));

    // Divide change mid-period on channel 0
    repeat (3) step(1'b0, 1'b0, "drop2");
    stepn = 0;
    repeat (45) begin
      if (stepn == 31) cur_d = pack3(2, 3, 0);
      step(1'b1, (stepn == 31), "redivide");
      if (stepn >= 30 && stepn <= 38) ce0v[stepn-30] = ce[0];
    end
    for (int k = 0; k < 9; k++) chk($sformatf("redivide_ce0_cyc%0d", k), 32'(ce0v[k]), 32'(exp_ce0[k]));

    // Random lock drops and configuration loads
    for (int n = 0; n < 700; n++) begin
      logic ld;
      ld = ($urandom_range(0, 19) == 0);
      if (ld) begin
        cur_d = pack3($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
        cur_p = pack3($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      end
      step(($urandom_range(0, 149) != 0), ld, "random");
    end

    // Async reset in the middle of RELEASE restores shadow defaults
    cur_d = pack3(3, 3, 3); cur_p = pack3(1, 1, 1);
    step(1'b0, 1'b1, "pre_rst");
    repeat (3) step(1'b0, 1'b0, "pre_rst");
    stepn = 0;
    repeat (22) step(1'b1, 1'b0, "mid_release");
    chk("mid_release_rst_out_n", 32'(rst_out_n), 32'b011);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ce", 32'(ce), 32'd0);
    chk("async_rst_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    stepn = 0; first_rdy = -1;
    repeat (40) begin
      step(1'b1, 1'b0, "post_rst");
      if (first_rdy < 0 && ready) first_rdy = stepn;
    end
    chk("post_rst_ready_step", 32'(first_rdy), 32'd30);
    chk("post_rst_ce_default", 32'(ce), 32'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
